pipe_stage_reg: RTL and testbench

- Generic inter-stage pipeline register for the 5-stage core; replaces the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a parametrised payload plus PC under a valid/ready handshake.
- Supports synchronous flush (bubble = all-zero nop) and an optional skid entry, so upstream ready can be registered instead of combinational.
- Counts downstream stall cycles for performance debug.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/pipe_entry_reg.sv | 44 ++++
 rtl/pipe_stage_reg.sv | 147 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the core's inter-stage registers: bubble value,
// stage payload widths and the occupancy/state encoding.
package cpu_pkg;

  // A bubble is an all-zero payload and PC, which decodes as a nop.
  localparam logic PIPE_BUBBLE = 1'b0;

  localparam int FD_DATA_W = 64;
  localparam int DE_DATA_W = 101;
  localparam int EM_DATA_W = 72;
  localparam int MW_DATA_W = 40;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  // State encoding equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = OCC_EMPTY,
    ST_ONE   = OCC_ONE,
    ST_TWO   = OCC_TWO
  } stage_state_t;

  function automatic logic [1:0] occ_of(stage_state_t s);
    logic [1:0] occ;
    occ = OCC_EMPTY;
    case (s)
      ST_ONE:  occ = OCC_ONE;
      ST_TWO:  occ = OCC_TWO;
      default: occ = OCC_EMPTY;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One {valid, data, pc} pipeline entry with load and clear; clear wins and
// returns the entry to the bubble value.
module pipe_entry_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = 101,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_data,
  input  logic [PC_W-1:0]   load_pc,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [PC_W-1:0]   pc
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic [PC_W-1:0]   pc_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= 1'b0;
      data_reg  <= {DATA_W{PIPE_BUBBLE}};
      pc_reg    <= {PC_W{PIPE_BUBBLE}};
    end else if (clear) begin
      valid_reg <= 1'b0;
      data_reg  <= {DATA_W{PIPE_BUBBLE}};
      pc_reg    <= {PC_W{PIPE_BUBBLE}};
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
      pc_reg    <= load_pc;
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;
  assign pc    = pc_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with optional skid entry,
// synchronous flush to bubble and a saturating downstream-stall counter.
module pipe_stage_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 101,
  parameter int PC_W    = 32,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_state_t state_reg, state_next;

  logic              accept, consume;
  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data, main_load_data;
  logic [PC_W-1:0]   main_pc, skid_pc, main_load_pc;
  logic [CNT_W-1:0]  stall_cnt_reg;

  assign accept  = in_valid && in_ready;
  assign consume = main_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_EMPTY;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next     = state_reg;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      // Flush beats any same-cycle accept or consume.
      state_next = ST_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            main_load  = 1'b1;
            state_next = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_load = 1'b1;
          end else if (accept && SKID_EN) begin
            skid_load  = 1'b1;
            state_next = ST_TWO;
          end else if (consume) begin
            main_clear = 1'b1;
            state_next = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (consume) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_next     = ST_ONE;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  assign main_load_data = main_from_skid ? skid_data : in_data;
  assign main_load_pc   = main_from_skid ? skid_pc   : in_pc;

  pipe_entry_reg #(.DATA_W(DATA_W), .PC_W(PC_W)) u_main (
    .clk       (clk),
    .reset     (reset),
    .load      (main_load),
    .clear     (main_clear),
    .load_data (main_load_data),
    .load_pc   (main_load_pc),
    .valid     (main_valid),
    .data      (main_data),
    .pc        (main_pc)
  );

  generate
    if (SKID_EN) begin : g_skid
      logic in_ready_reg;

      pipe_entry_reg #(.DATA_W(DATA_W), .PC_W(PC_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_data (in_data),
        .load_pc   (in_pc),
        .valid     (skid_valid),
        .data      (skid_data),
        .pc        (skid_pc)
      );

      // Registered ready: the skid entry absorbs the one-cycle lag.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) in_ready_reg <= 1'b1;
        else        in_ready_reg <= (state_next != ST_TWO);
      end
      assign in_ready = in_ready_reg;
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_data  = {DATA_W{PIPE_BUBBLE}};
      assign skid_pc    = {PC_W{PIPE_BUBBLE}};
      assign in_ready   = !main_valid || out_ready;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg <= '0;
    end else if (main_valid && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_pc    = main_pc;
  assign occupancy = occ_of(state_reg);
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed scoreboard bench: one skid-enabled stage (4-bit stall counter) and
// one single-entry stage share the same stimulus and are checked every cycle.
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic [100:0] in_data;
  logic [31:0]  in_pc;
  logic         out_ready;

  logic         a_in_ready, a_out_valid;
  logic [100:0] a_out_data;
  logic [31:0]  a_out_pc;
  logic [1:0]   a_occ;
  logic [3:0]   a_stall;

  logic         b_in_ready, b_out_valid;
  logic [100:0] b_out_data;
  logic [31:0]  b_out_pc;
  logic [1:0]   b_occ;
  logic [15:0]  b_stall;

  int checks   = 0;
  int failures = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int unsigned sa, sb;
  logic        rdy_a;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(101), .PC_W(32), .SKID_EN(1'b1), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_pc(in_pc),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_pc(a_out_pc), .occupancy(a_occ), .stall_cnt(a_stall)
  );

  pipe_stage_reg #(.DATA_W(101), .PC_W(32), .SKID_EN(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_pc(in_pc),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_pc(b_out_pc), .occupancy(b_occ), .stall_cnt(b_stall)
  );

  function automatic logic [100:0] mk(input logic [31:0] pc);
    return {37'h1_2345_6789, ~pc, pc};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0]  epc_a, epc_b;
    logic [100:0] ed_a, ed_b;
    epc_a = (qa.size() != 0) ? qa[0] : 32'h0;
    ed_a  = (qa.size() != 0) ? mk(qa[0]) : '0;
    epc_b = (qb.size() != 0) ? qb[0] : 32'h0;
    ed_b  = (qb.size() != 0) ? mk(qb[0]) : '0;
    chk("a_out_valid", {127'd0, a_out_valid}, {127'd0, qa.size() != 0});
    chk("a_out_pc",    {96'd0, a_out_pc},     {96'd0, epc_a});
    chk("a_out_data",  {27'd0, a_out_data},   {27'd0, ed_a});
    chk("a_occupancy", {126'd0, a_occ},       128'(qa.size()));
    chk("a_stall_cnt", {124'd0, a_stall},     128'(sa));
    chk("a_in_ready",  {127'd0, a_in_ready},  {127'd0, rdy_a});
    chk("b_out_valid", {127'd0, b_out_valid}, {127'd0, qb.size() != 0});
    chk("b_out_pc",    {96'd0, b_out_pc},     {96'd0, epc_b});
    chk("b_out_data",  {27'd0, b_out_data},   {27'd0, ed_b});
    chk("b_occupancy", {126'd0, b_occ},       128'(qb.size()));
    chk("b_stall_cnt", {112'd0, b_stall},     128'(sb));
  endtask

  // Drive one cycle of stimulus, update the scoreboards at the edge, check.
  task automatic step(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
    logic acc_a, acc_b, rdy_b;
    in_valid  = v;
    in_pc     = pc;
    in_data   = mk(pc);
    out_ready = ordy;
    flush     = fl;
    #1;
    rdy_b = (qb.size() == 0) || ordy;
    chk("a_in_ready_pre", {127'd0, a_in_ready}, {127'd0, rdy_a});
    chk("b_in_ready_comb", {127'd0, b_in_ready}, {127'd0, rdy_b});
    acc_a = v && rdy_a;
    acc_b = v && rdy_b;
    @(posedge clk);
    if (qa.size() != 0 && !ordy && sa != 15) sa++;
    if (qb.size() != 0 && !ordy && sb != 65535) sb++;
    if (fl) begin
      qa.delete();
      qb.delete();
    end else begin
      if (qa.size() != 0 && ordy) void'(qa.pop_front());
      if (acc_a) qa.push_back(pc);
      if (qb.size() != 0 && ordy) void'(qb.pop_front());
      if (acc_b) qb.push_back(pc);
    end
    rdy_a = (qa.size() != 2);
    #1;
    check_all();
    $display("step v=%0d pc=%h ordy=%0d flush=%0d | a: v=%0d pc=%h occ=%0d stall=%0d | b: v=%0d pc=%h occ=%0d stall=%0d",
             v, pc, ordy, fl, a_out_valid, a_out_pc, a_occ, a_stall,
             b_out_valid, b_out_pc, b_occ, b_stall);
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    sa = 0;
    sb = 0;
    rdy_a = 1'b1;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_pc = '0; out_ready = 1'b0;
    model_reset();
    #12;
    check_all();
    reset = 1'b1;
    @(posedge clk); #1;

    // Streaming with out_ready high.
    step(1'b1, 32'h3000, 1'b1, 1'b0);
    step(1'b1, 32'h3004, 1'b1, 1'b0);
    step(1'b1, 32'h3008, 1'b1, 1'b0);
    step(1'b0, 32'h0,    1'b1, 1'b0);

    // Backpressure into the skid entry, then drain in order.
    step(1'b1, 32'h3000, 1'b1, 1'b0);
    step(1'b1, 32'h3004, 1'b0, 1'b0);
    step(1'b0, 32'h0,    1'b0, 1'b0);
    step(1'b0, 32'h0,    1'b1, 1'b0);
    step(1'b0, 32'h0,    1'b1, 1'b0);

    // Flush while two entries are held, with a new entry offered.
    step(1'b1, 32'h3000, 1'b1, 1'b0);
    step(1'b1, 32'h3004, 1'b0, 1'b0);
    step(1'b1, 32'h300c, 1'b0, 1'b1);
    step(1'b0, 32'h0,    1'b1, 1'b0);

    // Asynchronous reset mid-cycle with two entries held.
    step(1'b1, 32'h3010, 1'b1, 1'b0);
    step(1'b1, 32'h3014, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    #1;
    reset = 1'b1;
    step(1'b1, 32'h3018, 1'b1, 1'b0);
    step(1'b0, 32'h0,    1'b1, 1'b0);

    // Single-entry stage refuses a second entry while stalled.
    step(1'b1, 32'h3020, 1'b0, 1'b0);
    step(1'b1, 32'h3024, 1'b0, 1'b0);
    step(1'b0, 32'h0,    1'b1, 1'b0);
    step(1'b0, 32'h0,    1'b1, 1'b0);

    // Stall counter saturation on the 4-bit instance.
    step(1'b1, 32'h3030, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("a_stall_saturated", {124'd0, a_stall}, 128'd15);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
